// File: rtl/hazard_scoreboard.sv
// ID-stage hazard unit: a shift-register scoreboard of in-flight writes drives
// the stall and forward selects, and a local counter tracks mult/div occupancy.
module hazard_scoreboard #(
    parameter int NUM_STAGES = 3,
    parameter int AW         = 5,
    parameter int TW         = 3,
    parameter int TUSE_INF   = 7,
    parameter int MULT_LAT   = 5,
    parameter int DIV_LAT    = 10,
    parameter int SW         = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          id_valid,
    input  logic [AW-1:0] id_rs,
    input  logic [AW-1:0] id_rt,
    input  logic [TW-1:0] id_tuse_rs,
    input  logic [TW-1:0] id_tuse_rt,
    input  logic [AW-1:0] id_dst,
    input  logic [TW-1:0] id_tnew,
    input  logic          id_md_use,
    input  logic          id_md_start,
    input  logic          id_md_div,
    input  logic          flush,
    output logic          stall,
    output logic          clr_ex,
    output logic [SW-1:0] fwd_rs_sel,
    output logic [SW-1:0] fwd_rt_sel,
    output logic          md_busy
);

    localparam int MD_MAX = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int MDW    = $clog2(MD_MAX + 1);

    logic [NUM_STAGES-1:0] v_q, v_d;
    logic [AW-1:0]         dst_q  [NUM_STAGES];
    logic [AW-1:0]         dst_d  [NUM_STAGES];
    logic [TW-1:0]         tnew_q [NUM_STAGES];
    logic [TW-1:0]         tnew_d [NUM_STAGES];
    logic [MDW-1:0]        md_cnt_q, md_cnt_d;

    logic          stall_rs, stall_rt, stall_md, issue;
    logic [SW-1:0] sel_rs, sel_rt;

    function automatic logic [TW-1:0] sat_dec(input logic [TW-1:0] x);
        return (x == '0) ? x : x - TW'(1);
    endfunction

    // Scan oldest to youngest so the youngest matching entry is the one kept.
    function automatic void lookup(input logic [AW-1:0] addr, input logic [TW-1:0] tuse,
                                   output logic stl, output logic [SW-1:0] sel);
        stl = 1'b0;
        sel = '0;
        if (id_valid && addr != '0 && tuse != TW'(TUSE_INF)) begin
            for (int i = NUM_STAGES - 1; i >= 0; i--) begin
                if (v_q[i] && dst_q[i] == addr) begin
                    sel = SW'(i + 1);
                    stl = (tnew_q[i] > tuse);
                end
            end
        end
    endfunction

    always_comb begin
        lookup(id_rs, id_tuse_rs, stall_rs, sel_rs);
        lookup(id_rt, id_tuse_rt, stall_rt, sel_rt);
    end

    assign md_busy    = (md_cnt_q != '0);
    assign stall_md   = md_busy & id_md_use & id_valid;
    assign stall      = stall_rs | stall_rt | stall_md;
    assign clr_ex     = stall;
    assign fwd_rs_sel = sel_rs;
    assign fwd_rt_sel = sel_rt;
    assign issue      = id_valid & ~stall & ~flush;

    always_comb begin
        v_d[0]    = issue & (id_dst != '0);
        dst_d[0]  = id_dst;
        tnew_d[0] = sat_dec(id_tnew);
        for (int i = 1; i < NUM_STAGES; i++) begin
            v_d[i]    = v_q[i-1];
            dst_d[i]  = dst_q[i-1];
            tnew_d[i] = sat_dec(tnew_q[i-1]);
        end
        if (flush) v_d = '0;
    end

    // The mult/div unit keeps running across a flush.
    always_comb begin
        md_cnt_d = md_cnt_q;
        if (issue && id_md_start)
            md_cnt_d = id_md_div ? MDW'(DIV_LAT) : MDW'(MULT_LAT);
        else if (md_cnt_q != '0)
            md_cnt_d = md_cnt_q - MDW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q      <= '0;
            md_cnt_q <= '0;
            for (int i = 0; i < NUM_STAGES; i++) tnew_q[i] <= '0;
        end else begin
            v_q      <= v_d;
            md_cnt_q <= md_cnt_d;
            for (int i = 0; i < NUM_STAGES; i++) tnew_q[i] <= tnew_d[i];
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_STAGES; i++) dst_q[i] <= dst_d[i];
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed pipeline scenarios followed by random
// traffic, all checked against an issue-history model of in-flight writes.
module tb_hazard_scoreboard;

    localparam int NS = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid;
    logic [4:0] id_rs, id_rt, id_dst;
    logic [2:0] id_tuse_rs, id_tuse_rt, id_tnew;
    logic       id_md_use, id_md_start, id_md_div, flush;
    logic       stall, clr_ex, md_busy;
    logic [1:0] fwd_rs_sel, fwd_rt_sel;

    hazard_scoreboard dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_tuse_rs(id_tuse_rs), .id_tuse_rt(id_tuse_rt), .id_dst(id_dst), .id_tnew(id_tnew),
        .id_md_use(id_md_use), .id_md_start(id_md_start), .id_md_div(id_md_div),
        .flush(flush), .stall(stall), .clr_ex(clr_ex), .fwd_rs_sel(fwd_rs_sel),
        .fwd_rt_sel(fwd_rt_sel), .md_busy(md_busy)
    );

    always #5 clk = ~clk;

    typedef struct { int dst; int tnew; int ic; } rec_t;
    rec_t q[$];
    int   cyc;
    int   md_until;
    int   checks;
    int   errors;
    int   exp_stall;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // Youngest issued writer of addr still inside the tracked window.
    function automatic void exp_op(input int valid, input int addr, input int tuse,
                                   output int stl, output int sel);
        int age, tn;
        stl = 0;
        sel = 0;
        if (valid != 0 && addr != 0 && tuse != 7) begin
            for (int k = q.size() - 1; k >= 0; k--) begin
                age = cyc - q[k].ic;
                if (age >= 1 && age <= NS && q[k].dst == addr) begin
                    tn  = (q[k].tnew > age) ? q[k].tnew - age : 0;
                    sel = age;
                    stl = (tn > tuse) ? 1 : 0;
                    break;
                end
            end
        end
    endfunction

    task automatic set_id(input int v, input int rs, input int trs, input int rt, input int trt,
                          input int dst, input int tn, input int mu, input int ms, input int md);
        id_valid    = v[0];
        id_rs       = rs[4:0];
        id_tuse_rs  = trs[2:0];
        id_rt       = rt[4:0];
        id_tuse_rt  = trt[2:0];
        id_dst      = dst[4:0];
        id_tnew     = tn[2:0];
        id_md_use   = mu[0];
        id_md_start = ms[0];
        id_md_div   = md[0];
        flush       = 1'b0;
    endtask

    task automatic idle();
        set_id(0, 0, 7, 0, 7, 0, 0, 0, 0, 0);
    endtask

    task automatic settle_check();
        int s_rs, s_rt, sel_rs, sel_rt, busy, s_md;
        #1;
        exp_op(id_valid, id_rs, id_tuse_rs, s_rs, sel_rs);
        exp_op(id_valid, id_rt, id_tuse_rt, s_rt, sel_rt);
        busy      = (cyc <= md_until) ? 1 : 0;
        s_md      = (busy != 0 && id_md_use && id_valid) ? 1 : 0;
        exp_stall = (s_rs != 0 || s_rt != 0 || s_md != 0) ? 1 : 0;
        chk("stall", stall, exp_stall);
        chk("clr_ex", clr_ex, exp_stall);
        chk("fwd_rs_sel", fwd_rs_sel, sel_rs);
        chk("fwd_rt_sel", fwd_rt_sel, sel_rt);
        chk("md_busy", md_busy, busy);
    endtask

    task automatic advance();
        bit iss;
        iss = id_valid && exp_stall == 0 && !flush;
        if (flush) q.delete();
        else if (iss && id_dst != 0) q.push_back('{int'(id_dst), int'(id_tnew), cyc});
        if (iss && id_md_start) md_until = cyc + (id_md_div ? 10 : 5);
        @(posedge clk);
        cyc++;
        while (q.size() > 0 && cyc - q[0].ic > NS) void'(q.pop_front());
        @(negedge clk);
    endtask

    task automatic drain(input int n);
        idle();
        for (int i = 0; i < n; i++) begin settle_check(); advance(); end
    endtask

    task automatic reset_now();
        rst_n = 1'b0;
        #1;
        chk("rst_stall", stall, 0);
        chk("rst_clr_ex", clr_ex, 0);
        chk("rst_md_busy", md_busy, 0);
        chk("rst_sel_rs", fwd_rs_sel, 0);
        chk("rst_sel_rt", fwd_rt_sel, 0);
        q.delete();
        md_until = -1000;
        idle();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        checks = 0; errors = 0; cyc = 0; md_until = -1000; exp_stall = 0;
        rst_n = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_stall", stall, 0);
        chk("reset_md_busy", md_busy, 0);
        chk("reset_sel_rs", fwd_rs_sel, 0);
        rst_n = 1'b1;
        drain(1);

        // lw $1 ; addu $2,$1,$3
        set_id(1, 0, 7, 0, 7, 1, 3, 0, 0, 0); settle_check(); advance();
        set_id(1, 1, 1, 3, 1, 2, 1, 0, 0, 0); settle_check(); chk("lw_addu_stall", stall, 1); advance();
        settle_check(); chk("lw_addu_go", stall, 0); chk("lw_addu_sel", fwd_rs_sel, 2); advance();
        drain(4);

        // lw $1 ; beq $1,$4
        set_id(1, 0, 7, 0, 7, 1, 3, 0, 0, 0); settle_check(); advance();
        set_id(1, 1, 0, 4, 0, 0, 0, 0, 0, 0);
        settle_check(); chk("beq_stall1", stall, 1); advance();
        settle_check(); chk("beq_stall2", stall, 1); advance();
        settle_check(); chk("beq_go", stall, 0); chk("beq_sel", fwd_rs_sel, 3); advance();
        drain(4);

        // lw $5 ; addu $5 ; subu $6,$5
        set_id(1, 0, 7, 0, 7, 5, 3, 0, 0, 0); settle_check(); advance();
        set_id(1, 0, 7, 0, 7, 5, 2, 0, 0, 0); settle_check(); advance();
        set_id(1, 5, 1, 0, 7, 6, 1, 0, 0, 0);
        settle_check(); chk("shadow_stall", stall, 0); chk("shadow_sel", fwd_rs_sel, 1); advance();
        drain(4);

        // $0 never matches; Tuse=INF never stalls
        set_id(1, 0, 7, 0, 7, 0, 3, 0, 0, 0); settle_check(); advance();
        set_id(1, 0, 1, 0, 1, 2, 1, 0, 0, 0);
        settle_check(); chk("r0_stall", stall, 0); chk("r0_sel", fwd_rs_sel, 0); advance();
        set_id(1, 0, 7, 0, 7, 7, 3, 0, 0, 0); settle_check(); advance();
        set_id(1, 7, 7, 0, 7, 3, 1, 0, 0, 0);
        settle_check(); chk("inf_stall", stall, 0); chk("inf_sel", fwd_rs_sel, 0); advance();
        drain(4);

        // mult then mflo; div then mflo
        for (int d = 0; d < 2; d++) begin
            set_id(1, 0, 7, 0, 7, 0, 0, 1, 1, d); settle_check(); advance();
            set_id(1, 0, 7, 0, 7, 3, 1, 1, 0, 0);
            for (int k = 0; k < (d ? 10 : 5); k++) begin
                settle_check(); chk("md_stall", stall, 1); chk("md_busy_on", md_busy, 1); advance();
            end
            settle_check(); chk("md_release", stall, 0); chk("md_busy_off", md_busy, 0); advance();
            drain(4);
        end

        // Asynchronous reset while stalled on both a load and the mult/div unit
        set_id(1, 0, 7, 0, 7, 0, 0, 1, 1, 0); settle_check(); advance();
        set_id(1, 0, 7, 0, 7, 1, 3, 0, 0, 0); settle_check(); advance();
        set_id(1, 1, 0, 0, 7, 0, 0, 1, 0, 0); settle_check(); chk("pre_rst_stall", stall, 1);
        chk("pre_rst_sel", fwd_rs_sel, 1);
        reset_now();
        drain(2);

        // Flush while lw sits in entry 0
        set_id(1, 0, 7, 0, 7, 1, 3, 0, 0, 0); settle_check(); advance();
        set_id(1, 1, 1, 0, 7, 2, 1, 0, 0, 0); flush = 1'b1; settle_check(); advance();
        set_id(1, 1, 1, 0, 7, 2, 1, 0, 0, 0);
        settle_check(); chk("flush_stall", stall, 0); chk("flush_sel", fwd_rs_sel, 0); advance();
        drain(4);

        for (int n = 0; n < 2000; n++) begin
            int ms, mu;
            ms = ($urandom % 12 == 0) ? 1 : 0;
            mu = (ms != 0 || $urandom % 8 == 0) ? 1 : 0;
            set_id(($urandom % 4 != 0) ? 1 : 0, $urandom % 4, $urandom % 8, $urandom % 4,
                   $urandom % 8, $urandom % 4, $urandom % 4, mu, ms, $urandom % 2);
            flush = ($urandom % 25 == 0);
            settle_check();
            advance();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the fixed EX/MEM hazard checker.
- Tracks in-flight register writes in a shift-register scoreboard with NUM_STAGES entries (stage 0 = EX, then MEM, WB, ...), each holding a self-decrementing Tnew.
- Produces ID-stage stall/bubble and per-operand forward-source selects.
- Contains a multiply/divide busy counter with configurable latencies, replacing the external MDBusy input.

Parameters:
- NUM_STAGES, 3, number of post-ID pipeline stages tracked (1..8)
- AW, 5, register address width
- TW, 3, Tnew/Tuse width
- TUSE_INF, 7, Tuse value meaning "operand not read"; must equal 2**TW-1
- MULT_LAT, 5, busy cycles after a mult/multu issues
- DIV_LAT, 10, busy cycles after a div/divu issues
- SW, 2, forward-select width; must satisfy 2**SW > NUM_STAGES

Ports:
- clk  in  1  clock; rising edge
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID holds a real instruction
- id_rs  in  AW  rs address
- id_rt  in  AW  rt address
- id_tuse_rs  in  TW  rs Tuse
- id_tuse_rt  in  TW  rt Tuse
- id_dst  in  AW  destination register (0 = none)
- id_tnew  in  TW  Tnew at ID
- id_md_use  in  1  instruction uses the mult/div unit (including mfhi/mflo/mthi/mtlo)
- id_md_start  in  1  instruction starts a mult/div op
- id_md_div  in  1  with id_md_start: 1 = divide latency, 0 = multiply latency
- flush  in  1  synchronous clear of all scoreboard entries
- stall  out  1  freeze PC and IF/ID
- clr_ex  out  1  insert bubble into EX; equals stall
- fwd_rs_sel  out  SW  0 = register file, k = stage k-1 entry
- fwd_rt_sel  out  SW  same, for rt
- md_busy  out  1  mult/div unit busy

Behaviour:
- Entry i holds {v, dst, tnew}. Reset (rst_n=0, asynchronous): all v=0, tnew=0, md counter=0. With no inputs asserted, outputs are stall=0, clr_ex=0, sel=0, md_busy=0. Reset mid-operation discards all in-flight state immediately.
- Issue: issue = id_valid & ~stall & ~flush.
- Every clock edge (shift):
  - Entry i+1 <= entry i, with tnew saturating-decremented (0 stays 0).
  - Entry 0 <= {issue & (id_dst!=0), id_dst, sat_dec(id_tnew)}.
  - The last entry is discarded.
  - Older entries shift even while stall=1; only stage 0 receives a bubble.
- flush=1: all entries valid=0 on that edge; flush takes priority over stall and issue.
- Operand match for rs (rt identical):
  - Find the lowest index i with v_i=1 and dst_i==id_rs. Youngest match wins; older matches are shadowed.
  - Operand ignored when id_rs==0, id_tuse_rs==TUSE_INF, or id_valid=0.
- stall_rs = match exists & tnew_i > id_tuse_rs.
- fwd_rs_sel = i+1 if a match exists, else 0. Valid regardless of stall; purely combinational.
- stall_md = md_busy & id_md_use & id_valid.
- stall = clr_ex = stall_rs | stall_rt | stall_md. All outputs are combinational from the entries and ID inputs; there is no added latency.
- MD counter (width covers max(MULT_LAT, DIV_LAT)):
  - On issue & id_md_start, load DIV_LAT or MULT_LAT.
  - Otherwise decrement when nonzero.
  - md_busy = (counter != 0).
  - Load takes priority over decrement.
  - flush does not clear the counter; the unit keeps running.
- id_tnew==0 (e.g. store or branch): the entry is still stored if dst!=0, with tnew 0, so it is forwardable immediately.
- Comparisons are unsigned TW-bit.

Test Plan:
- lw $1 (tnew=3) followed by addu $2,$1,$3 (tuse_rs=1): one stall cycle with entry0 tnew=2. Next cycle: stall=0, fwd_rs_sel=2.
- lw $1 followed by beq $1,$4 (tuse=0): stall for 2 cycles (tnew 2, then 1). Third cycle: stall=0, fwd_rs_sel=3 (NUM_STAGES=3).
- Shadowing: lw $5, then addu $5 (tnew=2), then subu $6,$5 (tuse=1): youngest entry0 tnew=1 gives stall=0, fwd_rs_sel=1. The older lw entry is ignored.
- $0 and TUSE_INF: lw $0, then addu reading $0 gives stall=0, sel=0. An operand with Tuse=TUSE_INF matching a pending lw gives no stall.
- mult (MULT_LAT=5), then mflo held in ID: md_busy=1 for 5 cycles and stall=1 for 5 cycles. Next cycle: stall=0. div gives 10 cycles.
- Reset/flush:
  - Drop rst_n mid-stall: stall falls asynchronously, md_busy=0, sel=0.
  - Assert flush while lw is in entry0: the next cycle shows no stall for a dependent instruction.
